uart_byte_rx: RTL and testbench
===============================

// Module: uart_byte_rx
// PURPOSE
//  - 8N1 UART receiver: serial line in, one byte + single-cycle done strobe out.
//  - Sits directly upstream of the command checker; its uart_rx_done and
//    uart_rx_data connect 1:1 to that stage's inputs of the same name.
//  - Detects framing errors (stop bit low) and suppresses the byte on error.
// PARAMETERS
//  CLK_FREQ   50_000_000  clk frequency in Hz
//  BAUD       115200      line rate in bit/s
//  (localparam) BIT_CYC = CLK_FREQ/BAUD (integer, truncated); HALF_CYC = BIT_CYC/2
//  (localparam) CNT_W = $clog2(BIT_CYC) - baud counter width
// PORTS
//  clk             in   1  system clock
//  rst_n           in   1  reset, asynchronous, active-low
//  uart_rxd        in   1  asynchronous serial line, idle high
//  uart_rx_data    out  8  last correctly framed byte, LSB received first
//  uart_rx_done    out  1  1-cycle pulse: new byte valid on uart_rx_data
//  uart_frame_err  out  1  1-cycle pulse: stop bit sampled low, byte dropped
// BEHAVIOUR
//  - Reset: uart_rx_data=8'h00, uart_rx_done=0, uart_frame_err=0, FSM=IDLE,
//    sync flops=1 (line idle), counters=0. Reset mid-frame aborts: no done/err.
//  - Input: 2-FF synchronizer, then 1 extra reg for edge detect (rxd_s, rxd_d).
//  - FSM states: IDLE, START, DATA, STOP, BREAK.
//    IDLE : rxd_d=1 & rxd_s=0 (falling edge) -> START, baud_cnt cleared.
//    START: at baud_cnt==HALF_CYC-1 sample rxd_s; 0 -> DATA (cnt=0, bit_idx=0);
//           1 -> IDLE (glitch, no output activity).
//    DATA : sample rxd_s each time baud_cnt==BIT_CYC-1 (i.e. bit centre);
//           shift into shift_reg[bit_idx]; after bit_idx 7 -> STOP.
//    STOP : at baud_cnt==BIT_CYC-1 sample rxd_s;
//           1 -> uart_rx_data<=shift_reg, uart_rx_done<=1, -> IDLE;
//           0 -> uart_frame_err<=1, uart_rx_data unchanged, -> BREAK.
//    BREAK: wait for rxd_s==1 (any duration), then -> IDLE. No edge armed
//           while in BREAK; a held-low line never produces a byte.
//  - baud_cnt: CNT_W bits, clears on every sample point and on state entry;
//    never wraps past BIT_CYC-1.
//  - Latency: done/err registered, high exactly 1 cycle, the cycle after the
//    stop-bit centre sample. uart_rx_data changes in the same cycle done rises
//    and holds until the next good byte.
//  - done and frame_err are mutually exclusive; never high in consecutive
//    cycles. Back-to-back frames (start bit immediately after stop) are accepted
//    because IDLE is re-entered at the stop-bit centre (half a bit early).
//  - BIT_CYC < 4 unsupported (elaboration-time check).
// STRUCTURE
//  - Shared header uart_defs.vh: FSM state encodings (3-bit), default
//    CLK_FREQ/BAUD, DATA_INC/DATA_DEC command byte constants for consumers.
//  - One sub-module: uart_sync (2-FF synchronizer, parameterized reset value,
//    reset to 1 here). FSM, baud counter, shifter stay in uart_byte_rx.
// TESTING (bench: CLK_FREQ=1_000_000, BAUD=100_000 -> BIT_CYC=10)
//  1. Drive 8N1 0x2B, idle high before/after -> exactly one uart_rx_done pulse,
//     uart_rx_data=8'h2B, frame_err never high; done 93..97 clk after start edge.
//  2. 0x2D then 0x2B with zero idle between stop and start -> two done pulses,
//     data 8'h2D then 8'h2B; no frame_err.
//  3. Low glitch of 3 clk on idle line -> no done, no err, FSM back in IDLE;
//     subsequent 0x41 received correctly.
//  4. 0x55 with stop bit low, line held low 40 clk then high -> one frame_err
//     pulse, no done, uart_rx_data keeps prior value; no activity until a new
//     falling edge; next 0xA5 -> done, data=8'hA5.
//  5. Assert rst_n low during bit 4 of 0xFF, release, send 0x00 -> outputs 0
//     during reset, no done for 0xFF, one done with data=8'h00.
//  6. Sweep all 256 byte values back-to-back -> 256 dones, data matches each.

Source files
------------

// File: rtl/uart_byte_rx_pkg.sv
// Shared definitions for the 8N1 UART byte receiver: FSM encoding, default line
// timing, and the command byte values the downstream command checker decodes.
package uart_byte_rx_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_DATA  = 3'd2,
      ST_STOP  = 3'd3,
      ST_BREAK = 3'd4
   } rx_state_t;

   localparam int DEF_CLK_FREQ = 50_000_000;
   localparam int DEF_BAUD     = 115_200;

   localparam logic [7:0] DATA_INC = 8'h2B;
   localparam logic [7:0] DATA_DEC = 8'h2D;

   function automatic int bit_cycles(input int clk_freq, input int baud);
      return clk_freq / baud;
   endfunction

endpackage

// File: rtl/uart_byte_rx_if.sv
// Serial line plus received-byte strobes between the UART receiver and its
// neighbours (line driver / command checker).
interface uart_byte_rx_if;
   logic       uart_rxd;
   logic [7:0] uart_rx_data;
   logic       uart_rx_done;
   logic       uart_frame_err;

   modport master (
      output uart_rxd,
      input  uart_rx_data,
      input  uart_rx_done,
      input  uart_frame_err
   );

   modport slave (
      input  uart_rxd,
      output uart_rx_data,
      output uart_rx_done,
      output uart_frame_err
   );
endinterface

// File: rtl/uart_byte_rx_sync.sv
// Two-flop synchronizer for an asynchronous single-bit input; the reset value
// is a parameter so an idle-high line does not look like an edge after reset.
module uart_sync #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);
   logic meta;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= RST_VAL;
         q    <= RST_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end
endmodule

// File: rtl/uart_byte_rx.sv
// 8N1 UART receiver: oversampled serial line in, one byte with a single-cycle
// done strobe out; bytes with a low stop bit are dropped and flagged instead.
//
// state | meaning
// IDLE  | line idle, armed for a falling edge
// START | counting to start-bit centre to reject glitches
// DATA  | sampling 8 data bits at bit centres, LSB first
// STOP  | sampling stop bit; high -> done, low -> frame error
// BREAK | line held low after a framing error, wait for it to go high
module uart_byte_rx
   import uart_byte_rx_pkg::*;
#(
   parameter int CLK_FREQ = DEF_CLK_FREQ,
   parameter int BAUD     = DEF_BAUD
) (
   input  logic           clk,
   input  logic           rst_n,
   uart_byte_rx_if.slave  rx_if
);
   localparam int BIT_CYC  = bit_cycles(CLK_FREQ, BAUD);
   localparam int HALF_CYC = BIT_CYC / 2;
   localparam int CNT_W    = $clog2(BIT_CYC);

   localparam logic [CNT_W-1:0] CNT_BIT_END  = CNT_W'(BIT_CYC - 1);
   localparam logic [CNT_W-1:0] CNT_HALF_END = CNT_W'(HALF_CYC - 1);

   if (BIT_CYC < 4) begin : g_bit_cyc_check
      $error("uart_byte_rx: CLK_FREQ/BAUD must be at least 4");
   end

   rx_state_t        state;
   logic             rxd_s;
   logic             rxd_d;
   logic [CNT_W-1:0] baud_cnt;
   logic [2:0]       bit_idx;
   logic [7:0]       shift_reg;
   logic [7:0]       data_q;
   logic             done_q;
   logic             err_q;

   uart_sync #(.RST_VAL(1'b1)) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (rx_if.uart_rxd),
      .q     (rxd_s)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         rxd_d     <= 1'b1;
         baud_cnt  <= '0;
         bit_idx   <= '0;
         shift_reg <= '0;
         data_q    <= '0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         rxd_d  <= rxd_s;
         done_q <= 1'b0;
         err_q  <= 1'b0;
         case (state)
            ST_IDLE: begin
               baud_cnt <= '0;
               if (rxd_d && !rxd_s) state <= ST_START;
            end
            ST_START: begin
               if (baud_cnt == CNT_HALF_END) begin
                  baud_cnt <= '0;
                  bit_idx  <= '0;
                  state    <= rxd_s ? ST_IDLE : ST_DATA;
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            ST_DATA: begin
               if (baud_cnt == CNT_BIT_END) begin
                  baud_cnt           <= '0;
                  shift_reg[bit_idx] <= rxd_s;
                  bit_idx            <= bit_idx + 1'b1;
                  if (bit_idx == 3'd7) state <= ST_STOP;
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            ST_STOP: begin
               if (baud_cnt == CNT_BIT_END) begin
                  baud_cnt <= '0;
                  if (rxd_s) begin
                     data_q <= shift_reg;
                     done_q <= 1'b1;
                     state  <= ST_IDLE;
                  end else begin
                     err_q <= 1'b1;
                     state <= ST_BREAK;
                  end
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            // Edge detector stays disarmed here so a held-low line never starts a frame.
            ST_BREAK: begin
               baud_cnt <= '0;
               if (rxd_s) state <= ST_IDLE;
            end
            default: begin
               baud_cnt <= '0;
               state    <= ST_IDLE;
            end
         endcase
      end
   end

   assign rx_if.uart_rx_data   = data_q;
   assign rx_if.uart_rx_done   = done_q;
   assign rx_if.uart_frame_err = err_q;

endmodule

// File: tb/tb_uart_byte_rx.sv
// Self-checking bench for uart_byte_rx: frames are driven on the serial line,
// expected outcomes queued at the start edge and matched when a strobe appears.
module tb_uart_byte_rx;
   import uart_byte_rx_pkg::*;

   localparam int BIT_CYC = 10;
   localparam int SYNC_LAT = 2;

   typedef struct {
      bit         is_err;
      logic [7:0] data;
      int         edge_cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;
   int   n_chk = 0;
   int   n_pass = 0;
   logic [7:0] last_good = 8'h00;
   bit   prev_pulse = 1'b0;
   exp_t sb[$];

   uart_byte_rx_if bus();

   uart_byte_rx #(.CLK_FREQ(1_000_000), .BAUD(100_000)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .rx_if (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_chk++;
      if (obs === exp_v) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp_v, cyc);
   endtask

   // Scoreboard monitor, sampled on the falling edge away from DUT updates.
   always @(negedge clk) begin
      exp_t e;
      bit   pulse;
      int   lat;
      if (rst_n) begin
         pulse = bus.uart_rx_done | bus.uart_frame_err;
         if (pulse) begin
            chk("done_err_exclusive", {31'd0, bus.uart_rx_done & bus.uart_frame_err}, 0);
            chk("no_consecutive_pulse", {31'd0, prev_pulse}, 0);
            if (sb.size() == 0) begin
               chk("unexpected_pulse", {30'd0, bus.uart_rx_done, bus.uart_frame_err}, 0);
            end else begin
               e = sb.pop_front();
               chk("pulse_kind_err", {31'd0, bus.uart_frame_err}, {31'd0, e.is_err});
               if (e.is_err) begin
                  chk("data_held_on_err", {24'd0, bus.uart_rx_data}, {24'd0, last_good});
               end else begin
                  chk("rx_data", {24'd0, bus.uart_rx_data}, {24'd0, e.data});
                  last_good = e.data;
               end
               lat = cyc - e.edge_cyc - SYNC_LAT;
               chk("latency_93_97", {31'd0, (lat >= 93 && lat <= 97)}, 1);
            end
         end
         prev_pulse = pulse;
      end else begin
         prev_pulse = 1'b0;
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drive_bit(input logic v);
      bus.uart_rxd = v;
      tick(BIT_CYC);
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop_v);
      exp_t e;
      e.is_err   = !stop_v;
      e.data     = b;
      e.edge_cyc = cyc;
      sb.push_back(e);
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(b[i]);
      drive_bit(stop_v);
   endtask

   task automatic drain(input string tag);
      for (int i = 0; i < 400 && sb.size() != 0; i++) @(posedge clk);
      #1;
      chk(tag, sb.size(), 0);
   endtask

   initial begin
      bus.uart_rxd = 1'b1;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_data", {24'd0, bus.uart_rx_data}, 0);
      chk("reset_done", {31'd0, bus.uart_rx_done}, 0);
      chk("reset_err",  {31'd0, bus.uart_frame_err}, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      tick(20);

      // Single byte with idle before and after.
      send_frame(DATA_INC, 1'b1);
      tick(30);
      drain("t1_drained");

      // Back-to-back, zero idle between stop and next start.
      send_frame(DATA_DEC, 1'b1);
      send_frame(DATA_INC, 1'b1);
      tick(30);
      drain("t2_drained");

      // Short low glitch must not start a frame.
      bus.uart_rxd = 1'b0;
      tick(3);
      bus.uart_rxd = 1'b1;
      tick(40);
      chk("t3_glitch_quiet", sb.size(), 0);
      send_frame(8'h41, 1'b1);
      tick(30);
      drain("t3_drained");

      // Framing error followed by a held-low line, then recovery.
      send_frame(8'h55, 1'b0);
      tick(40);
      bus.uart_rxd = 1'b1;
      tick(30);
      drain("t4_err_drained");
      send_frame(8'hA5, 1'b1);
      tick(30);
      drain("t4_drained");

      // Reset in the middle of bit 4 of 0xFF.
      bus.uart_rxd = 1'b0;
      tick(BIT_CYC);
      for (int i = 0; i < 4; i++) drive_bit(1'b1);
      bus.uart_rxd = 1'b1;
      tick(3);
      rst_n = 1'b0;
      last_good = 8'h00;
      @(negedge clk);
      chk("t5_rst_data", {24'd0, bus.uart_rx_data}, 0);
      chk("t5_rst_done", {31'd0, bus.uart_rx_done}, 0);
      chk("t5_rst_err",  {31'd0, bus.uart_frame_err}, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      tick(80);
      chk("t5_no_done_after_abort", sb.size(), 0);
      send_frame(8'h00, 1'b1);
      tick(30);
      drain("t5_drained");

      // Full byte sweep, back-to-back.
      for (int v = 0; v < 256; v++) send_frame(v[7:0], 1'b1);
      tick(30);
      drain("t6_drained");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
